// File: rtl/alu_seq.sv
// Sequential slice-serial ALU: ADD/AND/OR/XOR over WIDTH bits, SLICE bits per cycle.
// Optional accumulator operand select enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_zero,
    input  logic             b_inv,
    input  logic             carry_in,
    input  logic [1:0]       op,
`ifdef ALU_SEQ_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             zero,
    output logic             overflow
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, s_r, s_nx, b_eff, a_sel;
    logic [1:0]       op_r;
    logic             cy, c_r, zero_r, ov_r;
    logic [IW-1:0]    idx;
    logic [SLICE-1:0] sa, sb, res;
    logic [SLICE:0]   sum;
    logic             last, accept, is_add, cmsb_in;
    int               base;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST);
    assign is_add = (op_r == 2'b00);
    assign base   = int'(idx) * SLICE;

    always_comb begin
        b_eff = b_zero ? '0 : b;
        if (b_inv) b_eff = ~b_eff;
    end

`ifdef ALU_SEQ_ACC_EN
    // s_r still holds the last completed result while idle
    assign a_sel = acc_sel ? s_r : a;
`else
    assign a_sel = a;
`endif

    always_comb begin
        sa  = a_r[base +: SLICE];
        sb  = b_r[base +: SLICE];
        sum = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, cy};
        res = '0;
        unique case (op_r)
            2'b00:   res = sum[SLICE-1:0];
            2'b01:   res = sa & sb;
            2'b10:   res = sa | sb;
            default: res = sa ^ sb;
        endcase
        s_nx = s_r;
        s_nx[base +: SLICE] = res;
        cmsb_in = sum[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            cy     <= 1'b0;
            idx    <= '0;
            s_r    <= '0;
            c_r    <= 1'b0;
            zero_r <= 1'b0;
            ov_r   <= 1'b0;
        end else if (accept) begin
            a_r    <= a_sel;
            b_r    <= b_eff;
            op_r   <= op;
            cy     <= carry_in;
            idx    <= '0;
            s_r    <= '0;
            c_r    <= 1'b0;
            zero_r <= 1'b0;
            ov_r   <= 1'b0;
        end else if (state == RUN) begin
            s_r <= s_nx;
            if (is_add) cy <= sum[SLICE];
            idx <= last ? '0 : idx + IW'(1);
            if (last) begin
                c_r    <= is_add & sum[SLICE];
                ov_r   <= is_add & (cmsb_in ^ sum[SLICE]);
                zero_r <= (s_nx == '0);
            end
        end
    end

    assign s        = s_r;
    assign c        = c_r;
    assign zero     = zero_r;
    assign overflow = ov_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16, SLICE=4).
// Define ALU_SEQ_ACC_EN for both bench and RTL to exercise the accumulator path.
module tb_alu_seq;

    localparam int W   = 16;
    localparam int NSL = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, b_zero, b_inv, carry_in;
    logic [W-1:0] a, b, s;
    logic [1:0]   op;
    logic         out_valid, out_ready, c, zero, overflow;
`ifdef ALU_SEQ_ACC_EN
    logic         acc_sel;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .b_zero(b_zero), .b_inv(b_inv), .carry_in(carry_in),
        .op(op),
`ifdef ALU_SEQ_ACC_EN
        .acc_sel(acc_sel),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c),
        .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one request, wait for out_valid (bounded), return cycles and outputs
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic bz, input logic bi,
                          input logic ci, input logic acc, output int n,
                          output logic [W-1:0] rs, output logic [2:0] fl);
        @(negedge clk);
        op = o; a = av; b = bv; b_zero = bz; b_inv = bi; carry_in = ci;
`ifdef ALU_SEQ_ACC_EN
        acc_sel = acc;
`else
        if (acc) $display("note: acc_sel not built in");
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rs = s;
        fl = {c, zero, overflow};
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0 ||
            {c, zero, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b s=%h flags=%b want 1 0 0000 000",
                     in_ready, out_valid, s, {c, zero, overflow});
        end
    endtask

    task automatic test_add_basic();
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b00, 16'h1234, 16'h0FCD, 0, 0, 0, 0, n, rs, fl);
        checks++;
        if (n !== NSL) begin
            errors++;
            $display("FAIL add_latency: got %0d want %0d", n, NSL);
        end
        checks++;
        if (rs !== 16'h2201 || fl !== 3'b000) begin
            errors++;
            $display("FAIL add_basic: s=%h cz v=%b want 2201 000", rs, fl);
        end
        finish_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_acc();
`ifdef ALU_SEQ_ACC_EN
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b00, 16'h0000, 16'h0001, 0, 0, 0, 1, n, rs, fl);
        checks++;
        if (rs !== 16'h2202) begin
            errors++;
            $display("FAIL acc: s=%h want 2202", rs);
        end
        acc_sel = 1'b0;
        finish_op();
`endif
    endtask

    task automatic test_sub();
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b00, 16'h8000, 16'h0001, 0, 1, 1, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h7FFF || fl !== 3'b101) begin
            errors++;
            $display("FAIL sub: s=%h czv=%b want 7fff 101", rs, fl);
        end
        finish_op();
    endtask

    task automatic test_carry_zero();
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b00, 16'hFFFF, 16'h0001, 0, 0, 0, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h0000 || fl !== 3'b110) begin
            errors++;
            $display("FAIL add_wrap: s=%h czv=%b want 0000 110", rs, fl);
        end
        finish_op();
        run_op(2'b01, 16'hFFFF, 16'h5A5A, 1, 0, 1, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h0000 || fl !== 3'b010) begin
            errors++;
            $display("FAIL and_bzero: s=%h czv=%b want 0000 010", rs, fl);
        end
        finish_op();
    endtask

    task automatic test_logic();
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b10, 16'h00F0, 16'h0F00, 0, 0, 0, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h0FF0 || fl !== 3'b000) begin
            errors++;
            $display("FAIL or: s=%h czv=%b want 0ff0 000", rs, fl);
        end
        finish_op();
        run_op(2'b11, 16'h1234, 16'h1234, 0, 1, 1, 0, n, rs, fl);
        checks++;
        if (rs !== 16'hFFFF || fl !== 3'b000) begin
            errors++;
            $display("FAIL xor_inv: s=%h czv=%b want ffff 000", rs, fl);
        end
        finish_op();
        run_op(2'b01, 16'hF0F0, 16'h3C3C, 0, 0, 0, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h3030 || fl !== 3'b000) begin
            errors++;
            $display("FAIL and: s=%h czv=%b want 3030 000", rs, fl);
        end
        finish_op();
    endtask

    task automatic test_stall();
        int n; logic [W-1:0] rs; logic [2:0] fl;
        run_op(2'b00, 16'h7FFF, 16'h0001, 0, 0, 0, 0, n, rs, fl);
        checks++;
        if (rs !== 16'h8000 || fl !== 3'b001) begin
            errors++;
            $display("FAIL add_ovf: s=%h czv=%b want 8000 001", rs, fl);
        end
        op = 2'b10; a = 16'h0003; b = 16'h0030; b_zero = 0; b_inv = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 16'h8000 ||
                {c, zero, overflow} !== 3'b001) begin
                errors++;
                $display("FAIL stall_%0d: vld=%b rdy=%b s=%h czv=%b want 1 0 8000 001",
                         k, out_valid, in_ready, s, {c, zero, overflow});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: rdy=%b want 0", in_ready);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== NSL || s !== 16'h0033) begin
            errors++;
            $display("FAIL stall_next: n=%0d s=%h want %0d 0033", n, s, NSL);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        op = 2'b00; a = 16'h1111; b = 16'h2222; carry_in = 0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b vld=%b s=%h want 1 0 0000",
                     in_ready, out_valid, s);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_result: out_valid cycles=%0d want 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 0; a = '0; b = '0;
        b_zero = 0; b_inv = 0; carry_in = 0; op = 2'b00;
`ifdef ALU_SEQ_ACC_EN
        acc_sel = 1'b0;
`endif
        test_reset();
        test_add_basic();
        test_acc();
        test_sub();
        test_carry_zero();
        test_logic();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width; must be an integer multiple of SLICE.
REQ-002 SHALL have parameter SLICE, default 4: bits processed per RUN cycle; NSL = WIDTH/SLICE, NSL >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the operation request.
REQ-006 SHALL have port in_ready  output  1  high only in IDLE.
REQ-007 SHALL have ports a and b  input  WIDTH  the operands.
REQ-008 SHALL have port b_zero  input  1  forces b to 0 before inversion.
REQ-009 SHALL have port b_inv  input  1  inverts the effective b.
REQ-010 SHALL have port carry_in  input  1  carry into bit 0; ADD only.
REQ-011 SHALL have port op  input  2  00 ADD, 01 AND, 10 OR, 11 XOR.
REQ-012 SHALL have port out_valid  output  1  the result is available.
REQ-013 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-014 SHALL have port s  output  WIDTH  the result.
REQ-015 SHALL have ports c, zero and overflow  output  1 each  the result flags.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 SHALL treat in_valid && in_ready at a rising edge as accept: latch a, b_eff, carry_in and op; clear slice index and result; go IDLE->RUN.
REQ-018 SHALL compute b_eff = (b_zero ? 0 : b), then bitwise-inverted if b_inv.
REQ-019 SHALL, in RUN cycle i (0..NSL-1), compute slice bits [i*SLICE +: SLICE] from latched operands and the carry register; for ADD the slice carry-out goes to the carry register.
REQ-020 SHALL transition RUN->DONE at the edge that ends slice NSL-1, so out_valid is high NSL cycles after the accept edge.
REQ-021 SHALL hold s and the flags stable while DONE; DONE->IDLE at the edge where out_ready=1.
REQ-022 SHALL ignore in_valid in RUN and DONE, and ignore operand changes after accept.
REQ-023 SHALL set c = carry out of bit WIDTH-1 for ADD, 0 for logic ops.
REQ-024 SHALL set overflow = carry into MSB XOR carry out of MSB for ADD, 0 for logic ops.
REQ-025 SHALL set zero = (s == 0) for all ops.
REQ-026 SHALL not overlap a new accept with a result handshake: minimum spacing between accepts is NSL+2 cycles.
REQ-027 SHALL, with NSL=1, behave identically with one RUN cycle.

Reset
REQ-028 SHALL, with rst high at an edge in any state, go to IDLE with s=0, c=0, zero=0, overflow=0, out_valid=0, carry/index/operand registers 0, and in_ready=1 in the following cycle.
REQ-029 SHALL discard an in-flight operation on reset mid-RUN or mid-DONE; there is no partial result.

Configuration
REQ-030 SHALL, with ALU_SEQ_ACC_EN defined, add port acc_sel (input, 1): when acc_sel=1 at accept, the latched a is the last completed result (cleared by reset).
REQ-031 SHALL, without ALU_SEQ_ACC_EN, have no acc_sel port and always latch a.

Verification (WIDTH=16, SLICE=4)
REQ-032 SHALL verify ADD a=0x1234, b=0x0FCD, carry_in=0 -> s=0x2201, c=0, overflow=0, zero=0, out_valid high exactly 4 cycles after accept.
REQ-033 SHALL verify SUB a=0x8000, b=0x0001, b_inv=1, carry_in=1 -> s=0x7FFF, c=1, overflow=1, zero=0.
REQ-034 SHALL verify ADD a=0xFFFF, b=0x0001 -> s=0x0000, c=1, zero=1, overflow=0; and AND a=0xFFFF with b_zero=1 -> s=0, zero=1, c=0.
REQ-035 SHALL verify out_ready held low 3 cycles in DONE with in_valid=1 -> out_valid, s and flags stable, in_ready=0, no new accept; accept occurs only after return to IDLE.
REQ-036 SHALL verify rst pulsed during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, s=0, and no result is emitted.
REQ-037 SHALL verify, with ALU_SEQ_ACC_EN, that after the result 0x2201, an accept with acc_sel=1, op=ADD, b=0x0001 gives s=0x2202.
